preg_free_list: RTL and testbench
=================================

PREG_FREE_LIST -- requirements
Module: preg_free_list

Interface
REQ-001 SHALL have parameter NUM_PREGS, 64, physical register count.
REQ-002 SHALL have parameter NUM_AREGS, 32, architectural register count; pregs 0..NUM_AREGS-1 are mapped at reset, never on the list at reset.
REQ-003 SHALL have parameter ALLOC_WIDTH, RENAME_WIDTH, allocation lanes per cycle.
REQ-004 SHALL have parameter FREE_WIDTH, 2, release/retire lanes per cycle.
REQ-005 SHALL derive DEPTH = NUM_PREGS-NUM_AREGS (power of two, elaboration error otherwise) and PREG_W = $clog2(NUM_PREGS).
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 rst  in  1  synchronous, active-low reset.
REQ-008 alloc_req  in  ALLOC_WIDTH  per-lane request for one free preg (lanes in program order, gaps allowed).
REQ-009 alloc_ok  out  1  whole group granted this cycle.
REQ-010 alloc_preg  out  ALLOC_WIDTH x PREG_W  preg per requesting lane.
REQ-011 rel_valid  in  FREE_WIDTH  per-lane release of a stale preg from commit.
REQ-012 rel_preg  in  FREE_WIDTH x PREG_W  preg being released.
REQ-013 retire_cnt  in  $clog2(ALLOC_WIDTH*FREE_WIDTH+1)  allocations made non-speculative this cycle.
REQ-014 flush  in  1  squash all speculative allocations.
REQ-015 free_count  out  $clog2(DEPTH+1)  non-speculatively-free entries available for alloc.
REQ-016 overflow_err  out  1  sticky error flag.

Function
REQ-017 Storage SHALL be a DEPTH-entry circular buffer with spec_head, commit_head, tail pointers, each log2(DEPTH)+1 bits (wrap bit).
REQ-018 free_count SHALL equal tail - spec_head (modular, wrap-bit form), registered-state derived, combinational output.
REQ-019 Let n = popcount(alloc_req); alloc_ok SHALL be 1 iff n <= free_count and flush = 0 (n = 0 gives alloc_ok = 1).
REQ-020 alloc_preg[i] SHALL be buf[spec_head + k], k = number of requesting lanes below i; lanes with alloc_req[i]=0 output 0; outputs combinational, same cycle.
REQ-021 Allocation is all-or-nothing: on alloc_ok & n>0, spec_head SHALL advance by n next edge; otherwise unchanged.
REQ-022 Releases SHALL be compacted in lane order: j-th valid lane written to buf[tail + j]; tail advances by popcount(rel_valid); written pregs visible to allocation next cycle, never same cycle.
REQ-023 Release when tail - commit_head would exceed DEPTH SHALL drop the excess lanes and set overflow_err until reset.
REQ-024 commit_head SHALL advance by retire_cnt each edge; retire_cnt exceeding spec_head - commit_head SHALL saturate at spec_head and set overflow_err.
REQ-025 On flush, spec_head SHALL load commit_head + retire_cnt (same-cycle retire honoured); same-cycle alloc ignored; same-cycle releases accepted.
REQ-026 Pointer arithmetic SHALL wrap modulo 2*DEPTH; full = (tail - commit_head == DEPTH), empty = (free_count == 0).

Reset
REQ-027 While rst=0 at an edge: buf[i] = NUM_AREGS+i, spec_head = commit_head = 0, tail = DEPTH (wrap bit set, index 0), overflow_err = 0.
REQ-028 After reset: free_count = DEPTH, alloc_ok = 1 for any request, alloc_preg lanes per REQ-020.
REQ-029 Reset mid-operation SHALL discard all in-flight allocations and releases of that cycle.

Structure
REQ-030 NUM_PREGS, NUM_AREGS, RENAME_WIDTH, FREE_WIDTH and a preg_t typedef SHALL live in CORE_PKG.
REQ-031 One sub-module, popcount_prefix (per-lane prefix count + total), SHALL be shared by the alloc and release paths.
REQ-032 Storage SHALL be flops (multi-write), no RAM macro.

Verification
REQ-033 Reset, alloc_req=2'b11 -> alloc_ok=1, alloc_preg={33,32}; next cycle free_count=30.
REQ-034 alloc_req=2'b10 after reset -> lane1 gets 32, lane0 gets 0; free_count 31 next cycle.
REQ-035 Drain to free_count=1, alloc_req=2'b11 -> alloc_ok=0, spec_head unchanged; alloc_req=2'b01 -> granted.
REQ-036 Alloc 4, retire_cnt=1, flush same cycle -> free_count=31; next alloc returns preg 33.
REQ-037 Allocate 32, release {40,41}, then alloc 2'b11 same cycle as release -> alloc_ok=0; next cycle alloc_preg={41,40}.
REQ-038 Reset state, rel_valid=2'b01 -> overflow_err=1 stays set, free_count stays 32.

Source files
------------

// File: rtl/core_pkg.sv
// Core-wide rename parameters shared by the free list and its bench.
package core_pkg;
  localparam int NUM_PREGS    = 64;
  localparam int NUM_AREGS    = 32;
  localparam int RENAME_WIDTH = 2;
  localparam int FREE_WIDTH   = 2;
  localparam int PREG_W       = $clog2(NUM_PREGS);

  typedef logic [PREG_W-1:0] preg_t;
endpackage

// File: rtl/popcount_prefix.sv
// Per-lane count of set bits below each lane, plus the total set-bit count.
module popcount_prefix #(
  parameter int N = 2,
  localparam int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         bits,
  output logic [N-1:0][CW-1:0] prefix,
  output logic [CW-1:0]        total
);

  logic [CW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < N; i++) begin
      prefix[i] = acc;
      acc = acc + CW'(bits[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/preg_free_list.sv
// Physical register free list: circular buffer with speculative and committed
// allocation heads, so a flush restores every speculatively taken preg.
module preg_free_list #(
  parameter int NUM_PREGS   = core_pkg::NUM_PREGS,
  parameter int NUM_AREGS   = core_pkg::NUM_AREGS,
  parameter int ALLOC_WIDTH = core_pkg::RENAME_WIDTH,
  parameter int FREE_WIDTH  = core_pkg::FREE_WIDTH,
  localparam int DEPTH  = NUM_PREGS - NUM_AREGS,
  localparam int PREG_W = $clog2(NUM_PREGS),
  localparam int RC_W   = $clog2(ALLOC_WIDTH * FREE_WIDTH + 1),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [ALLOC_WIDTH-1:0]              alloc_req,
  output logic                                alloc_ok,
  output logic [ALLOC_WIDTH-1:0][PREG_W-1:0]  alloc_preg,
  input  logic [FREE_WIDTH-1:0]               rel_valid,
  input  logic [FREE_WIDTH-1:0][PREG_W-1:0]   rel_preg,
  input  logic [RC_W-1:0]                     retire_cnt,
  input  logic                                flush,
  output logic [CNT_W-1:0]                    free_count,
  output logic                                overflow_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int ACW   = $clog2(ALLOC_WIDTH + 1);
  localparam int FCW   = $clog2(FREE_WIDTH + 1);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
      $error("preg_free_list: NUM_PREGS-NUM_AREGS must be a power of two >= 2");
    end
  endgenerate

  logic [PREG_W-1:0] entries [DEPTH];
  logic [PTR_W-1:0]  spec_head, commit_head, tail;

  logic [ALLOC_WIDTH-1:0][ACW-1:0]   a_prefix;
  logic [ACW-1:0]                    a_total;
  logic [FREE_WIDTH-1:0][FCW-1:0]    r_prefix;
  logic [FCW-1:0]                    r_total;

  popcount_prefix #(.N(ALLOC_WIDTH)) u_alloc_cnt (
    .bits   (alloc_req),
    .prefix (a_prefix),
    .total  (a_total)
  );

  popcount_prefix #(.N(FREE_WIDTH)) u_rel_cnt (
    .bits   (rel_valid),
    .prefix (r_prefix),
    .total  (r_total)
  );

  logic [PTR_W-1:0] free_ptr, occ, room, inflight, rel_acc, commit_next, spec_next;
  logic             full, empty, rel_drop, ret_over;
  logic [ALLOC_WIDTH-1:0][IDX_W-1:0] a_idx;
  logic [FREE_WIDTH-1:0][IDX_W-1:0]  w_idx;
  logic [FREE_WIDTH-1:0]             rel_ok;

  assign free_ptr   = tail - spec_head;
  assign free_count = CNT_W'(free_ptr);
  assign empty      = (free_ptr == '0);
  assign alloc_ok   = !flush && ((a_total == '0) || (!empty && (PTR_W'(a_total) <= free_ptr)));

  always_comb begin
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      a_idx[i]      = spec_head[IDX_W-1:0] + IDX_W'(a_prefix[i]);
      alloc_preg[i] = alloc_req[i] ? entries[a_idx[i]] : '0;
    end
  end

  // Releases may only refill slots whose allocations have committed.
  assign occ      = tail - commit_head;
  assign full     = (occ == PTR_W'(DEPTH));
  assign room     = full ? '0 : PTR_W'(DEPTH) - occ;
  assign rel_drop = PTR_W'(r_total) > room;
  assign rel_acc  = rel_drop ? room : PTR_W'(r_total);

  always_comb begin
    for (int j = 0; j < FREE_WIDTH; j++) begin
      w_idx[j]  = tail[IDX_W-1:0] + IDX_W'(r_prefix[j]);
      rel_ok[j] = rel_valid[j] && (PTR_W'(r_prefix[j]) < room);
    end
  end

  assign inflight    = spec_head - commit_head;
  assign ret_over    = PTR_W'(retire_cnt) > inflight;
  assign commit_next = ret_over ? spec_head : commit_head + PTR_W'(retire_cnt);
  assign spec_next   = flush    ? commit_next :
                       alloc_ok ? spec_head + PTR_W'(a_total) : spec_head;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= PREG_W'(NUM_AREGS + i);
      end
      spec_head    <= '0;
      commit_head  <= '0;
      tail         <= PTR_W'(DEPTH);
      overflow_err <= 1'b0;
    end else begin
      spec_head   <= spec_next;
      commit_head <= commit_next;
      tail        <= tail + rel_acc;
      if (rel_drop || ret_over) overflow_err <= 1'b1;
      for (int j = 0; j < FREE_WIDTH; j++) begin
        if (rel_ok[j]) entries[w_idx[j]] <= rel_preg[j];
      end
    end
  end

endmodule

// File: tb/tb_preg_free_list.sv
// Directed bench for preg_free_list: a vector table plus reset/drain/flush/release sequences.
module tb_preg_free_list;
  import core_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      alloc_req;
  logic            alloc_ok;
  logic [1:0][5:0] alloc_preg;
  logic [1:0]      rel_valid;
  logic [1:0][5:0] rel_preg;
  logic [2:0]      retire_cnt;
  logic            flush;
  logic [5:0]      free_count;
  logic            overflow_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  preg_free_list dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_ok     (alloc_ok),
    .alloc_preg   (alloc_preg),
    .rel_valid    (rel_valid),
    .rel_preg     (rel_preg),
    .retire_cnt   (retire_cnt),
    .flush        (flush),
    .free_count   (free_count),
    .overflow_err (overflow_err)
  );

  typedef struct {
    logic [1:0] req;
    logic [1:0] rv;
    preg_t      r0;
    preg_t      r1;
    logic [2:0] rc;
    logic       fl;
    logic       ok;
    preg_t      p0;
    preg_t      p1;
    logic [5:0] fc;
    logic       ovf;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive at the falling edge; outputs are sampled 1ns later.
  task automatic set_in(input logic [1:0] req, input logic [1:0] rv, input preg_t r0,
                        input preg_t r1, input logic [2:0] rc, input logic fl);
    @(negedge clk);
    alloc_req   = req;
    rel_valid   = rv;
    rel_preg[0] = r0;
    rel_preg[1] = r1;
    retire_cnt  = rc;
    flush       = fl;
    #1;
  endtask

  task automatic idle();
    set_in(2'b00, 2'b00, 6'd0, 6'd0, 3'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    alloc_req = '0; rel_valid = '0; rel_preg = '0; retire_cnt = '0; flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //           req    rv     r0     r1    rc    fl   ok    p0     p1     fc    ovf
    vecs[0]  = '{2'b11, 2'b00, 6'd0,  6'd0, 3'd0, 1'b0, 1'b1, 6'd32, 6'd33, 6'd32, 1'b0};
    vecs[1]  = '{2'b00, 2'b00, 6'd0,  6'd0, 3'd0, 1'b0, 1'b1, 6'd0,  6'd0,  6'd30, 1'b0};
    vecs[2]  = '{2'b10, 2'b00, 6'd0,  6'd0, 3'd0, 1'b0, 1'b1, 6'd0,  6'd34, 6'd30, 1'b0};
    vecs[3]  = '{2'b01, 2'b00, 6'd0,  6'd0, 3'd0, 1'b0, 1'b1, 6'd35, 6'd0,  6'd29, 1'b0};
    vecs[4]  = '{2'b00, 2'b00, 6'd0,  6'd0, 3'd2, 1'b0, 1'b1, 6'd0,  6'd0,  6'd28, 1'b0};
    vecs[5]  = '{2'b11, 2'b00, 6'd0,  6'd0, 3'd0, 1'b1, 1'b0, 6'd36, 6'd37, 6'd28, 1'b0};
    vecs[6]  = '{2'b11, 2'b00, 6'd0,  6'd0, 3'd0, 1'b0, 1'b1, 6'd34, 6'd35, 6'd30, 1'b0};
    vecs[7]  = '{2'b00, 2'b01, 6'd50, 6'd0, 3'd0, 1'b0, 1'b1, 6'd0,  6'd0,  6'd28, 1'b0};
    vecs[8]  = '{2'b00, 2'b00, 6'd0,  6'd0, 3'd0, 1'b0, 1'b1, 6'd0,  6'd0,  6'd29, 1'b0};
    vecs[9]  = '{2'b00, 2'b00, 6'd0,  6'd0, 3'd3, 1'b0, 1'b1, 6'd0,  6'd0,  6'd29, 1'b0};
    vecs[10] = '{2'b00, 2'b00, 6'd0,  6'd0, 3'd0, 1'b0, 1'b1, 6'd0,  6'd0,  6'd29, 1'b1};
    vecs[11] = '{2'b11, 2'b00, 6'd0,  6'd0, 3'd0, 1'b0, 1'b1, 6'd36, 6'd37, 6'd29, 1'b1};
    vecs[12] = '{2'b00, 2'b00, 6'd0,  6'd0, 3'd0, 1'b0, 1'b1, 6'd0,  6'd0,  6'd27, 1'b1};

    do_reset();
    idle();
    check("reset_free_count", free_count, 32);
    check("reset_overflow", overflow_err, 0);
    check("reset_alloc_ok", alloc_ok, 1);

    for (int k = 0; k < 13; k++) begin
      set_in(vecs[k].req, vecs[k].rv, vecs[k].r0, vecs[k].r1, vecs[k].rc, vecs[k].fl);
      check($sformatf("vec%0d_alloc_ok", k), alloc_ok, vecs[k].ok);
      check($sformatf("vec%0d_preg0", k), alloc_preg[0], vecs[k].p0);
      check($sformatf("vec%0d_preg1", k), alloc_preg[1], vecs[k].p1);
      check($sformatf("vec%0d_free_count", k), free_count, vecs[k].fc);
      check($sformatf("vec%0d_overflow", k), overflow_err, vecs[k].ovf);
    end

    // Single high lane after reset
    do_reset();
    set_in(2'b10, 2'b00, 6'd0, 6'd0, 3'd0, 1'b0);
    check("lane1_only_ok", alloc_ok, 1);
    check("lane1_only_preg1", alloc_preg[1], 32);
    check("lane1_only_preg0", alloc_preg[0], 0);
    idle();
    check("lane1_only_free", free_count, 31);

    // Drain to one entry, then over-ask, then fit
    do_reset();
    for (int k = 0; k < 15; k++) set_in(2'b11, 2'b00, 6'd0, 6'd0, 3'd0, 1'b0);
    set_in(2'b01, 2'b00, 6'd0, 6'd0, 3'd0, 1'b0);
    set_in(2'b11, 2'b00, 6'd0, 6'd0, 3'd0, 1'b0);
    check("drain_free_one", free_count, 1);
    check("drain_overask_ok", alloc_ok, 0);
    set_in(2'b01, 2'b00, 6'd0, 6'd0, 3'd0, 1'b0);
    check("drain_still_one", free_count, 1);
    check("drain_fit_ok", alloc_ok, 1);
    check("drain_fit_preg0", alloc_preg[0], 63);
    set_in(2'b01, 2'b00, 6'd0, 6'd0, 3'd0, 1'b0);
    check("drain_empty_free", free_count, 0);
    check("drain_empty_ok", alloc_ok, 0);
    idle();
    check("drain_empty_zero_req_ok", alloc_ok, 1);

    // Flush with same-cycle retire
    do_reset();
    set_in(2'b11, 2'b00, 6'd0, 6'd0, 3'd0, 1'b0);
    set_in(2'b11, 2'b00, 6'd0, 6'd0, 3'd0, 1'b0);
    set_in(2'b00, 2'b00, 6'd0, 6'd0, 3'd1, 1'b1);
    check("flush_free_before", free_count, 28);
    set_in(2'b01, 2'b00, 6'd0, 6'd0, 3'd0, 1'b0);
    check("flush_free_after", free_count, 31);
    check("flush_next_preg0", alloc_preg[0], 33);

    // Full allocation, retire, release with same-cycle alloc
    do_reset();
    for (int k = 0; k < 16; k++) set_in(2'b11, 2'b00, 6'd0, 6'd0, 3'd0, 1'b0);
    set_in(2'b00, 2'b00, 6'd0, 6'd0, 3'd2, 1'b0);
    check("full_free_zero", free_count, 0);
    set_in(2'b11, 2'b11, 6'd40, 6'd41, 3'd0, 1'b0);
    check("rel_same_cycle_ok", alloc_ok, 0);
    set_in(2'b11, 2'b00, 6'd0, 6'd0, 3'd0, 1'b0);
    check("rel_next_free", free_count, 2);
    check("rel_next_ok", alloc_ok, 1);
    check("rel_next_preg0", alloc_preg[0], 40);
    check("rel_next_preg1", alloc_preg[1], 41);
    check("rel_no_overflow", overflow_err, 0);

    // Release into a full list sets the sticky error
    do_reset();
    set_in(2'b00, 2'b01, 6'd5, 6'd0, 3'd0, 1'b0);
    idle();
    check("ovf_set", overflow_err, 1);
    check("ovf_free_unchanged", free_count, 32);
    idle();
    check("ovf_sticky", overflow_err, 1);
    check("ovf_list_intact_preg0", alloc_preg[0], 0);
    set_in(2'b01, 2'b00, 6'd0, 6'd0, 3'd0, 1'b0);
    check("ovf_list_intact_alloc", alloc_preg[0], 32);
    do_reset();
    idle();
    check("ovf_cleared_by_reset", overflow_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
